// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
package mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ost_e;

   // Width of a channel index; at least one bit even for two channels.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Channel-side and output-side handshake bundle of the arbitrating mux.
interface rr_arb_mux_if #(
   parameter int N_IN  = 4,
   parameter int WIDTH = 16
);
   import mux_pkg::*;
   localparam int SEL_W = sel_w(N_IN);

   logic [N_IN-1:0][WIDTH-1:0] in_data;
   logic [N_IN-1:0]            in_valid;
   logic [N_IN-1:0]            in_ready;
   logic                       mode;
   logic [SEL_W-1:0]           sel;
   logic [WIDTH-1:0]           out_data;
   logic [SEL_W-1:0]           out_src;
   logic                       out_valid;
   logic                       out_ready;

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_src, out_valid
   );

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_src, out_valid
   );
endinterface

// File: rtl/rr_arb_mux_rr_pick.sv
// Rotating priority picker: first requester at or above start_i, wrapping.
module rr_pick
   import mux_pkg::*;
#(
   parameter  int N_IN  = 4,
   localparam int SEL_W = sel_w(N_IN)
) (
   input  logic [N_IN-1:0]  req_i,
   input  logic [SEL_W-1:0] start_i,
   output logic [N_IN-1:0]  gnt_o,
   output logic [SEL_W-1:0] idx_o,
   output logic             any_o
);

   int c;

   // Scan channels in rotated order; the first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      c     = 0;
      for (int k = 0; k < N_IN; k++) begin
         c = int'(start_i) + k;
         if (c >= N_IN) c = c - N_IN;
         if (!any_o && req_i[c]) begin
            any_o    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = SEL_W'(c);
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating mux with a one-entry registered output stage.
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_arb_mux_if.slave  bus
);

   localparam int               SEL_W    = sel_w(N_IN);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

   ost_e             state_q;
   logic [WIDTH-1:0] data_q;
   logic [SEL_W-1:0] src_q;
   logic [SEL_W-1:0] last_q;

   mode_e            mode;
   logic [SEL_W-1:0] start;
   logic [N_IN-1:0]  rr_gnt, fx_gnt, gnt;
   logic [SEL_W-1:0] rr_idx, gnt_idx;
   logic             rr_any, load_ok, load;

   assign mode  = mode_e'(bus.mode);
   // Search begins just past the last channel that actually transferred.
   assign start = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

   rr_pick #(.N_IN(N_IN)) u_pick (
      .req_i   (bus.in_valid),
      .start_i (start),
      .gnt_o   (rr_gnt),
      .idx_o   (rr_idx),
      .any_o   (rr_any)
   );

   // Fixed mode: only the selected channel may win; out-of-range sel grants nothing.
   always_comb begin
      fx_gnt = '0;
      for (int i = 0; i < N_IN; i++)
         fx_gnt[i] = (int'(bus.sel) == i) && bus.in_valid[i];
   end

   // Choose the grant source according to the current mode.
   always_comb begin
      if (mode == MODE_RR) begin
         gnt     = rr_gnt;
         gnt_idx = rr_idx;
      end else begin
         gnt     = fx_gnt;
         gnt_idx = bus.sel;
      end
   end

   // A load is allowed when the stage is empty or is draining this cycle.
   assign load_ok      = (state_q == ST_EMPTY) || bus.out_ready;
   assign load         = rst_n && load_ok && (|gnt);
   assign bus.in_ready = load ? gnt : '0;

   // Output stage FSM, held word and fairness pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         src_q   <= '0;
         last_q  <= LAST_IDX;
      end else if (load) begin
         state_q <= ST_FULL;
         data_q  <= bus.in_data[gnt_idx];
         src_q   <= gnt_idx;
         last_q  <= gnt_idx;
      end else if (state_q == ST_FULL && bus.out_ready) begin
         state_q <= ST_EMPTY;
      end
   end

   assign bus.out_valid = (state_q == ST_FULL);
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;

endmodule
